// File: rtl/limit_interlock.sv
// Float over/under limit interlock with sticky per-direction fault flags.
// Optional LIMIT_FILTER_EN: faults need P_FILT_CNT consecutive violations.
module limit_interlock #(
  parameter int P_FILT_CNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic [31:0] i_data,
  input  logic        i_over_en,
  input  logic [31:0] i_over_sp,
  input  logic        i_under_en,
  input  logic [31:0] i_under_sp,
  output logic        o_over_int,
  output logic        o_under_int,
  output logic        o_int
);

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  // a > b in sign-magnitude order; +0 and -0 compare equal
  function automatic logic fp_gt(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic r;
    if (a[30:0] == '0 && b[30:0] == '0)
      r = 1'b0;
    else if (a[31] != b[31])
      r = b[31];
    else if (!a[31])
      r = a[30:0] > b[30:0];
    else
      r = a[30:0] < b[30:0];
    return r;
  endfunction

  logic over_cond;
  logic under_cond;
  logic over_hit;
  logic under_hit;

  // NaN data fails safe; NaN setpoint disables its direction
  always_comb begin
    over_cond  = 1'b0;
    under_cond = 1'b0;
    if (i_over_en && !is_nan(i_over_sp))
      over_cond = is_nan(i_data) || fp_gt(i_data, i_over_sp);
    if (i_under_en && !is_nan(i_under_sp))
      under_cond = is_nan(i_data) || fp_gt(i_under_sp, i_data);
  end

`ifdef LIMIT_FILTER_EN
  localparam int CW = $clog2(P_FILT_CNT + 1);
  localparam logic [CW-1:0] SAT = CW'(P_FILT_CNT);
  localparam logic [CW-1:0] ARM = CW'(P_FILT_CNT - 1);

  logic [CW-1:0] over_cnt;
  logic [CW-1:0] under_cnt;

  // saturating consecutive-violation counters
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      over_cnt  <= '0;
      under_cnt <= '0;
    end else begin
      if (!over_cond)
        over_cnt <= '0;
      else if (over_cnt != SAT)
        over_cnt <= over_cnt + 1'b1;
      if (!under_cond)
        under_cnt <= '0;
      else if (under_cnt != SAT)
        under_cnt <= under_cnt + 1'b1;
    end
  end

  assign over_hit  = over_cond && (over_cnt >= ARM);
  assign under_hit = under_cond && (under_cnt >= ARM);
`else
  assign over_hit  = over_cond;
  assign under_hit = under_cond;
`endif

  // sticky fault flags; reset beats clear beats detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_over_int  <= 1'b0;
      o_under_int <= 1'b0;
    end else if (i_clr) begin
      o_over_int  <= 1'b0;
      o_under_int <= 1'b0;
    end else begin
      o_over_int  <= o_over_int | over_hit;
      o_under_int <= o_under_int | under_hit;
    end
  end

  // summary interlock lags the flags by one edge
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_int <= 1'b0;
    else
      o_int <= o_over_int | o_under_int;
  end

endmodule

// File: tb/tb_limit_interlock.sv
// Scoreboard bench for limit_interlock (default build, no filter).
// Stimulus pushes hand-computed {over,under,int}; monitor pops at negedge.
module tb_limit_interlock;

  localparam logic [31:0] Z    = 32'h0000_0000;
  localparam logic [31:0] NZ   = 32'h8000_0000;
  localparam logic [31:0] DEN  = 32'h0000_0001;
  localparam logic [31:0] H05  = 32'h3F00_0000;
  localparam logic [31:0] H08  = 32'h3F4C_CCCD;
  localparam logic [31:0] H12  = 32'h3F99_999A;
  localparam logic [31:0] H03  = 32'h3E99_999A;
  localparam logic [31:0] M10  = 32'hBF80_0000;
  localparam logic [31:0] M05  = 32'hBF00_0000;
  localparam logic [31:0] M20  = 32'hC000_0000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] data = '0;
  logic        over_en = 1'b0;
  logic [31:0] over_sp = '0;
  logic        under_en = 1'b0;
  logic [31:0] under_sp = '0;
  logic        over_int;
  logic        under_int;
  logic        any_int;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];
  string      name_q[$];
  bit done = 1'b0;

  always #5 clk = ~clk;

  limit_interlock dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (clr),
    .i_data     (data),
    .i_over_en  (over_en),
    .i_over_sp  (over_sp),
    .i_under_en (under_en),
    .i_under_sp (under_sp),
    .o_over_int (over_int),
    .o_under_int(under_int),
    .o_int      (any_int)
  );

  task automatic step(
    input string       nm,
    input logic        r,
    input logic        c,
    input logic [31:0] d,
    input logic        oe,
    input logic [31:0] os,
    input logic        ue,
    input logic [31:0] us,
    input logic [2:0]  e
  );
    rst = r;
    clr = c;
    data = d;
    over_en = oe;
    over_sp = os;
    under_en = ue;
    under_sp = us;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor: compare outputs against scoreboard once per cycle
  initial begin
    logic [2:0] e;
    logic [2:0] a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = {over_int, under_int, any_int};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got o/u/i=%b want %b", nm, a, e);
        end
      end
    end
  end

  initial begin
    step("reset",     1,0,Z,   0,Z,   0,Z,   3'b000);
    step("t1_over",   0,0,H08, 1,H05, 0,Z,   3'b100);
    step("t1_hold1",  0,0,Z,   1,H05, 0,Z,   3'b101);
    for (int i = 2; i <= 5; i++)
      step("t1_hold",  0,0,Z,   1,H05, 0,Z,   3'b101);
    step("t1_clr",    0,1,Z,   1,H05, 0,Z,   3'b001);
    step("t1_idle",   0,0,Z,   1,H05, 0,Z,   3'b000);
    step("t2_dis",    0,0,H12, 0,H05, 0,Z,   3'b000);
    step("t2_equal",  0,0,H05, 1,H05, 0,Z,   3'b000);
    step("zero_eq",   0,0,NZ,  1,Z,   0,Z,   3'b000);
    step("denorm",    0,0,DEN, 1,Z,   0,Z,   3'b100);
    step("dn_clr",    0,1,Z,   0,Z,   0,Z,   3'b001);
    step("dn_idle",   0,0,Z,   0,Z,   0,Z,   3'b000);
    step("t3_under",  0,0,Z,   0,H05, 1,H03, 3'b010);
    step("t3_sticky", 0,0,H12, 0,H05, 1,H03, 3'b011);
    step("t3_clr",    0,1,H12, 0,H05, 1,H03, 3'b001);
    step("t3_stay0",  0,0,H12, 0,H05, 1,H03, 3'b000);
    step("t3_stay0b", 0,0,H12, 0,H05, 1,H03, 3'b000);
    step("t4_neg",    0,0,M10, 0,H05, 1,H03, 3'b010);
    step("t4_clrhi",  0,1,M10, 0,H05, 1,H03, 3'b001);
    step("t4_clrhi2", 0,1,M10, 0,H05, 1,H03, 3'b000);
    step("t4_reset",  0,0,M10, 0,H05, 1,H03, 3'b010);
    step("t4_int",    0,0,M10, 0,H05, 1,H03, 3'b011);
    step("neg_clr",   0,1,Z,   0,H05, 1,H03, 3'b001);
    step("neg_gt",    0,0,M05, 0,H05, 1,M10, 3'b000);
    step("neg_lt",    0,0,M20, 0,H05, 1,M10, 3'b010);
    step("neg_clr2",  0,1,Z,   0,H05, 0,H03, 3'b001);
    step("neg_idle",  0,0,Z,   0,H05, 0,H03, 3'b000);
    step("t5_nan",    0,0,QNAN,1,H05, 1,H03, 3'b110);
    step("t5_int",    0,0,QNAN,1,H05, 1,H03, 3'b111);
    step("t5_rst",    1,1,QNAN,1,H05, 1,H03, 3'b000);
    step("nan_sp",    0,0,PINF,1,QNAN,0,H03, 3'b000);
    step("inf_over",  0,0,PINF,1,H05, 0,H03, 3'b100);
    step("t6_dis",    0,0,QNAN,0,H05, 0,H03, 3'b101);
    step("t6_hold",   0,0,QNAN,0,H05, 0,H03, 3'b101);
    step("t6_clr",    0,1,QNAN,0,H05, 0,H03, 3'b001);
    step("t6_idle",   0,0,QNAN,0,H05, 0,H03, 3'b000);
    done = 1'b1;
  end

  // wait for the scoreboard to drain, bounded
  initial begin
    int cyc;
    cyc = 0;
    while (!(done && exp_q.size() == 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    if (!done || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
